// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy edge pipeline: default frame geometry,
// pixel width and the window generator's FSM encoding.
package fuzzy_pkg;
   localparam int DEF_PIX_W      = 8;
   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } win_state_e;
endpackage

// File: rtl/fv_line_buf.sv
// One image row of pixel storage: combinational read, synchronous write.
// Contents are not reset; stale data is masked by row gating upstream.
module fv_line_buf #(
   parameter  int DEPTH = 640,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem_q [DEPTH];

   assign rdata = mem_q[addr];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end
endmodule

// File: rtl/window_3x3_gen.sv
// Raster stream to 3x3 neighbourhood generator (two line buffers + 3x3 shift window).
// Define WIN_OUT_REG_EN to add an output register stage (latency 2 instead of 1).
module window_3x3_gen
   import fuzzy_pkg::*;
#(
   parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter  int PIX_W      = DEF_PIX_W,
   localparam int CW         = $clog2(IMG_WIDTH),
   localparam int RW         = $clog2(IMG_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output logic [PIX_W-1:0] z0, z1, z2, z3, z4, z5, z6, z7, z8,
   output logic             win_valid,
   output logic [CW-1:0]    win_col,
   output logic [RW-1:0]    win_row,
   output logic             frame_done
);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   win_state_e                 state_q, state_d;
   logic [CW-1:0]              col_q, col_d, cur_col;
   logic [RW-1:0]              row_q, row_d, cur_row;
   logic [2:0][2:0][PIX_W-1:0] win_q, win_d;   // [row][col], col 2 = newest
   logic                       vld_q, vld_d, fd_q, fd_d;
   logic [CW-1:0]              wcol_q, wcol_d;
   logic [RW-1:0]              wrow_q, wrow_d;
   logic                       accept, last_pix;
   logic [PIX_W-1:0]           tap1, tap2;

   // A sof pixel is always (0,0), even when it interrupts a running frame.
   assign accept   = pix_valid && (sof || state_q == ACTIVE);
   assign cur_col  = sof ? '0 : col_q;
   assign cur_row  = sof ? '0 : row_q;
   assign last_pix = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

   fv_line_buf #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb0 (
      .clk(clk), .we(accept), .addr(cur_col), .wdata(pix_in), .rdata(tap1)
   );
   fv_line_buf #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb1 (
      .clk(clk), .we(accept), .addr(cur_col), .wdata(tap1), .rdata(tap2)
   );

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      vld_d   = 1'b0;
      fd_d    = 1'b0;
      wcol_d  = wcol_q;
      wrow_d  = wrow_q;
      if (accept) begin
         state_d = last_pix ? IDLE : ACTIVE;
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = last_pix ? '0 : cur_row + RW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = tap2;
         win_d[1][2] = tap1;
         win_d[2][2] = pix_in;
         // Window only once all three columns and rows lie inside the frame.
         if (cur_row >= RW'(2) && cur_col >= CW'(2)) begin
            vld_d  = 1'b1;
            wcol_d = cur_col - CW'(1);
            wrow_d = cur_row - RW'(1);
         end
         fd_d = last_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         vld_q   <= 1'b0;
         fd_q    <= 1'b0;
         wcol_q  <= '0;
         wrow_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         win_q   <= win_d;
         vld_q   <= vld_d;
         fd_q    <= fd_d;
         wcol_q  <= wcol_d;
         wrow_q  <= wrow_d;
      end
   end

   logic [2:0][2:0][PIX_W-1:0] win_o;
   logic                       vld_o, fd_o;
   logic [CW-1:0]              wcol_o;
   logic [RW-1:0]              wrow_o;

`ifdef WIN_OUT_REG_EN
   // Free-running stage: it keeps loading during stalls so win_valid still drops.
   logic [2:0][2:0][PIX_W-1:0] win_o_q;
   logic                       vld_o_q, fd_o_q;
   logic [CW-1:0]              wcol_o_q;
   logic [RW-1:0]              wrow_o_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         win_o_q  <= '0;
         vld_o_q  <= 1'b0;
         fd_o_q   <= 1'b0;
         wcol_o_q <= '0;
         wrow_o_q <= '0;
      end else begin
         win_o_q  <= win_q;
         vld_o_q  <= vld_q;
         fd_o_q   <= fd_q;
         wcol_o_q <= wcol_q;
         wrow_o_q <= wrow_q;
      end
   end

   assign win_o  = win_o_q;
   assign vld_o  = vld_o_q;
   assign fd_o   = fd_o_q;
   assign wcol_o = wcol_o_q;
   assign wrow_o = wrow_o_q;
`else
   assign win_o  = win_q;
   assign vld_o  = vld_q;
   assign fd_o   = fd_q;
   assign wcol_o = wcol_q;
   assign wrow_o = wrow_q;
`endif

   assign {z0, z1, z2} = {win_o[0][0], win_o[0][1], win_o[0][2]};
   assign {z3, z4, z5} = {win_o[1][0], win_o[1][1], win_o[1][2]};
   assign {z6, z7, z8} = {win_o[2][0], win_o[2][1], win_o[2][2]};
   assign win_valid    = vld_o;
   assign win_col      = wcol_o;
   assign win_row      = wrow_o;
   assign frame_done   = fd_o;
endmodule
